// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared encodings for the maze game sequencer
package game_pkg;

  localparam logic [3:0] GS_MENU    = 4'b0001;
  localparam logic [3:0] GS_IN_GAME = 4'b0010;
  localparam logic [3:0] GS_LOST    = 4'b0100;
  localparam logic [3:0] GS_WON     = 4'b1000;

  localparam logic [2:0] MS_START = 3'b001;
  localparam logic [2:0] MS_DIFF  = 3'b010;
  localparam logic [2:0] MS_INSTR = 3'b100;

  localparam logic [2:0] DIFF_EASY = 3'b001;
  localparam logic [2:0] DIFF_MED  = 3'b010;
  localparam logic [2:0] DIFF_HARD = 3'b100;

  localparam logic [2:0] S_MENU  = 3'd0;
  localparam logic [2:0] S_SHOW  = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_LOST  = 3'd4;
  localparam logic [2:0] S_WON   = 3'd5;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int TIMER_W = 27;

  // One-hot rotations over three entries, wrapping at both ends.
  function automatic logic [2:0] rot_next(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

  function automatic logic [2:0] rot_prev(input logic [2:0] v);
    return {v[0], v[2:1]};
  endfunction

endpackage

// File: rtl/maze_game_sequencer_if.sv
// rtl/maze_game_sequencer_if.sv - buttons, map ROM port and renderer outputs of the sequencer
interface maze_game_sequencer_if;
  logic [3:0]  dir_pulse;
  logic        sel_pulse;
  logic [4:0]  rom_addr;
  logic [29:0] rom_data;
  logic [3:0]  game_state;
  logic [2:0]  menu_sel;
  logic [2:0]  difficulty;
  logic        map_visible;
  logic [7:0]  player_x;
  logic [7:0]  player_y;
  logic        lost;
  logic        won;

  modport master (
    input  dir_pulse, sel_pulse, rom_data,
    output rom_addr, game_state, menu_sel, difficulty, map_visible,
           player_x, player_y, lost, won
  );

  modport slave (
    output dir_pulse, sel_pulse, rom_data,
    input  rom_addr, game_state, menu_sel, difficulty, map_visible,
           player_x, player_y, lost, won
  );
endinterface

// File: rtl/reveal_timer.sv
// rtl/reveal_timer.sv - loadable down-counter timing the map reveal
module reveal_timer #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);
  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Flags the last counting cycle so the owner leaves on the following edge.
  assign expire = (count == W'(1));
endmodule

// File: rtl/maze_game_sequencer.sv
// rtl/maze_game_sequencer.sv - game FSM, menu/difficulty selection and wall-checked movement
module maze_game_sequencer
  import game_pkg::*;
#(
  parameter int MAP_W     = 30,
  parameter int MAP_H     = 21,
  parameter int START_X   = 0,
  parameter int START_Y   = 20,
  parameter int GOAL_X    = 29,
  parameter int GOAL_Y    = 0,
  parameter int SHOW_EASY = 100000000,
  parameter int SHOW_MED  = 50000000,
  parameter int SHOW_HARD = 25000000,
  parameter int ROM_LAT   = 1
) (
  input logic                  clk,
  input logic                  reset,
  maze_game_sequencer_if.master bus
);
  localparam logic signed [8:0] MAP_W_S = 9'(MAP_W);
  localparam logic signed [8:0] MAP_H_S = 9'(MAP_H);

  logic [2:0]          state;
  logic [2:0]          menu_sel;
  logic [2:0]          difficulty;
  logic                map_visible;
  logic [7:0]          player_x;
  logic [7:0]          player_y;
  logic [4:0]          rom_addr;
  logic [7:0]          cand_x;
  logic [7:0]          cand_y;
  logic [1:0]          wait_cnt;
  logic [TIMER_W-1:0]  show_load;
  logic                timer_load;
  logic                timer_expire;
  logic signed [8:0]   step_x;
  logic signed [8:0]   step_y;
  logic signed [8:0]   next_x;
  logic signed [8:0]   next_y;
  logic                move_ok;
  logic                wall_hit;
  logic [3:0]          game_state;

  always_comb begin
    step_x = '0;
    step_y = '0;
    if (bus.dir_pulse[DIR_UP])         step_y = -9'sd1;
    else if (bus.dir_pulse[DIR_DOWN])  step_y = 9'sd1;
    else if (bus.dir_pulse[DIR_LEFT])  step_x = -9'sd1;
    else if (bus.dir_pulse[DIR_RIGHT]) step_x = 9'sd1;
  end

  // Signed 9-bit so a step left/up from 0 shows up as a negative coordinate.
  assign next_x  = $signed({1'b0, player_x}) + step_x;
  assign next_y  = $signed({1'b0, player_y}) + step_y;
  assign move_ok = (|bus.dir_pulse) &&
                   next_x >= 9'sd0 && next_x < MAP_W_S &&
                   next_y >= 9'sd0 && next_y < MAP_H_S;

  always_comb begin
    show_load = TIMER_W'(SHOW_EASY);
    if (difficulty == DIFF_MED)       show_load = TIMER_W'(SHOW_MED);
    else if (difficulty == DIFF_HARD) show_load = TIMER_W'(SHOW_HARD);
  end

  assign timer_load = (state == S_MENU) && bus.sel_pulse && (menu_sel == MS_START);
  assign wall_hit   = bus.rom_data[cand_x[4:0]];

  reveal_timer #(.W(TIMER_W)) u_reveal_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (show_load),
    .en       (state == S_SHOW),
    .expire   (timer_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_MENU;
      menu_sel    <= MS_START;
      difficulty  <= DIFF_EASY;
      map_visible <= 1'b0;
      player_x    <= 8'(START_X);
      player_y    <= 8'(START_Y);
      rom_addr    <= '0;
      cand_x      <= '0;
      cand_y      <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_MENU: begin
          if (bus.sel_pulse) begin
            if (menu_sel == MS_START) begin
              map_visible <= 1'b1;
              player_x    <= 8'(START_X);
              player_y    <= 8'(START_Y);
              state       <= S_SHOW;
            end
          end else if (bus.dir_pulse[DIR_UP]) begin
            menu_sel <= rot_prev(menu_sel);
          end else if (bus.dir_pulse[DIR_DOWN]) begin
            menu_sel <= rot_next(menu_sel);
          end else if (menu_sel == MS_DIFF) begin
            if (bus.dir_pulse[DIR_LEFT])       difficulty <= rot_prev(difficulty);
            else if (bus.dir_pulse[DIR_RIGHT]) difficulty <= rot_next(difficulty);
          end
        end
        S_SHOW: begin
          if (timer_expire) begin
            map_visible <= 1'b0;
            state       <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (move_ok) begin
            rom_addr <= next_y[4:0];
            cand_x   <= next_x[7:0];
            cand_y   <= next_y[7:0];
            wait_cnt <= '0;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          // The ROM row for cand_y is valid once ROM_LAT edges have passed.
          if (wait_cnt == 2'(ROM_LAT)) begin
            if (wall_hit) begin
              state <= S_LOST;
            end else begin
              player_x <= cand_x;
              player_y <= cand_y;
              if (cand_x == 8'(GOAL_X) && cand_y == 8'(GOAL_Y)) state <= S_WON;
              else                                            state <= S_PLAY;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        default: begin
          if (bus.sel_pulse) begin
            player_x <= 8'(START_X);
            player_y <= 8'(START_Y);
            state    <= S_MENU;
          end
        end
      endcase
    end
  end

  always_comb begin
    case (state)
      S_MENU:  game_state = GS_MENU;
      S_LOST:  game_state = GS_LOST;
      S_WON:   game_state = GS_WON;
      default: game_state = GS_IN_GAME;
    endcase
  end

  assign bus.game_state  = game_state;
  assign bus.menu_sel    = menu_sel;
  assign bus.difficulty  = difficulty;
  assign bus.map_visible = map_visible;
  assign bus.player_x    = player_x;
  assign bus.player_y    = player_y;
  assign bus.rom_addr    = rom_addr;
  assign bus.lost        = (state == S_LOST);
  assign bus.won         = (state == S_WON);
endmodule

// File: tb/tb_maze_game_sequencer.sv
// tb/tb_maze_game_sequencer.sv - scoreboard bench for maze_game_sequencer against a behavioural game model
module tb_maze_game_sequencer;
  localparam int MAP_W = 30, MAP_H = 21, SX = 0, SY = 20, GX = 29, GY = 0;
  localparam int SE = 10, SM = 6, SH = 3, LAT = 1;
  localparam int MD_MENU = 0, MD_SHOW = 1, MD_PLAY = 2, MD_CHECK = 3, MD_LOST = 4, MD_WON = 5;

  typedef struct packed {
    logic [3:0] gs;
    logic [2:0] ms;
    logic [2:0] df;
    logic       vis;
    logic [7:0] x;
    logic [7:0] y;
    logic [4:0] ra;
    logic       lost;
    logic       won;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  maze_game_sequencer_if bus();

  maze_game_sequencer #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .START_X(SX), .START_Y(SY), .GOAL_X(GX), .GOAL_Y(GY),
    .SHOW_EASY(SE), .SHOW_MED(SM), .SHOW_HARD(SH), .ROM_LAT(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [29:0] map_mem [0:31];
  logic [29:0] rom_pipe [0:LAT-1];

  // Synchronous map ROM with LAT register stages.
  always @(posedge clk) begin
    rom_pipe[0] <= map_mem[bus.rom_addr];
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_data = rom_pipe[LAT-1];

  int errors = 0;
  int checks = 0;
  obs_t exp_q[$];

  int m_mode, m_menu, m_diff, m_x, m_y, m_ra, m_vis, m_show, m_chk, m_cx, m_cy;
  int show_len[3] = '{SE, SM, SH};

  function automatic string fmt(input obs_t o);
    return $sformatf("gs=%b ms=%b df=%b vis=%b pos=(%0d,%0d) ra=%0d lost=%b won=%b",
                     o.gs, o.ms, o.df, o.vis, o.x, o.y, o.ra, o.lost, o.won);
  endfunction

  function automatic obs_t sample_dut();
    obs_t o;
    o.gs = bus.game_state; o.ms = bus.menu_sel; o.df = bus.difficulty;
    o.vis = bus.map_visible; o.x = bus.player_x; o.y = bus.player_y;
    o.ra = bus.rom_addr; o.lost = bus.lost; o.won = bus.won;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    case (m_mode)
      MD_MENU: o.gs = 4'b0001;
      MD_LOST: o.gs = 4'b0100;
      MD_WON:  o.gs = 4'b1000;
      default: o.gs = 4'b0010;
    endcase
    o.ms = 3'(1 << m_menu);
    o.df = 3'(1 << m_diff);
    o.vis = (m_vis != 0);
    o.x = 8'(m_x);
    o.y = 8'(m_y);
    o.ra = 5'(m_ra);
    o.lost = (m_mode == MD_LOST);
    o.won = (m_mode == MD_WON);
    return o;
  endfunction

  function automatic void check_obs(input string nm, input obs_t act, input obs_t expd);
    checks++;
    if (act !== expd) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", nm, fmt(act), fmt(expd));
    end
  endfunction

  function automatic void model_reset();
    m_mode = MD_MENU; m_menu = 0; m_diff = 0; m_x = SX; m_y = SY;
    m_ra = 0; m_vis = 0; m_show = 0; m_chk = 0; m_cx = 0; m_cy = 0;
  endfunction

  function automatic void model_step(input logic [3:0] d, input logic s);
    int dx, dy, nx, ny;
    dx = 0; dy = 0;
    if (d[0]) dy = -1; else if (d[1]) dy = 1; else if (d[2]) dx = -1; else if (d[3]) dx = 1;
    case (m_mode)
      MD_MENU: begin
        if (s) begin
          if (m_menu == 0) begin
            m_show = show_len[m_diff]; m_vis = 1; m_x = SX; m_y = SY; m_mode = MD_SHOW;
          end
        end else if (dy != 0) begin
          m_menu = (m_menu + 3 + dy) % 3;
        end else if (dx != 0 && m_menu == 1) begin
          m_diff = (m_diff + 3 + dx) % 3;
        end
      end
      MD_SHOW: begin
        m_show--;
        if (m_show == 0) begin m_mode = MD_PLAY; m_vis = 0; end
      end
      MD_PLAY: begin
        if (d != 0) begin
          nx = m_x + dx; ny = m_y + dy;
          if (nx >= 0 && nx < MAP_W && ny >= 0 && ny < MAP_H) begin
            m_ra = ny; m_cx = nx; m_cy = ny; m_chk = LAT + 1; m_mode = MD_CHECK;
          end
        end
      end
      MD_CHECK: begin
        m_chk--;
        if (m_chk == 0) begin
          if (map_mem[m_cy][m_cx]) m_mode = MD_LOST;
          else begin
            m_x = m_cx; m_y = m_cy;
            m_mode = (m_x == GX && m_y == GY) ? MD_WON : MD_PLAY;
          end
        end
      end
      default: if (s) begin m_mode = MD_MENU; m_x = SX; m_y = SY; end
    endcase
  endfunction

  // Scoreboard monitor: one expected observation per clock edge.
  obs_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_obs("cycle", sample_dut(), mon_e);
    end
  end

  // Tasks start on a falling edge and end on the next one.
  task automatic cycle(input logic [3:0] d, input logic s);
    bus.dir_pulse = d;
    bus.sel_pulse = s;
    model_step(d, s);
    exp_q.push_back(model_obs());
    @(negedge clk);
    bus.dir_pulse = '0;
    bus.sel_pulse = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(4'b0000, 1'b0);
  endtask

  task automatic wait_play();
    for (int k = 0; k < 40 && m_mode != MD_PLAY; k++) cycle(4'b0000, 1'b0);
  endtask

  task automatic async_reset(input string nm);
    bus.dir_pulse = '0;
    bus.sel_pulse = 1'b0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_obs(nm, sample_dut(), model_obs());
    exp_q.push_back(model_obs());
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic random_map();
    for (int r = 0; r < 32; r++)
      map_mem[r] = 30'($urandom) & 30'($urandom) & 30'($urandom);
    map_mem[SY][SX] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bus.dir_pulse = '0;
    bus.sel_pulse = 1'b0;
    for (int r = 0; r < 32; r++) map_mem[r] = '0;
    model_reset();
    @(negedge clk);
    async_reset("reset_state");

    // Menu navigation and difficulty selection.
    cycle(4'b0010, 1'b0); cycle(4'b0010, 1'b0); cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b0); cycle(4'b1000, 1'b0); cycle(4'b1000, 1'b0);
    cycle(4'b0001, 1'b0); cycle(4'b0000, 1'b1);
    idle(4);

    // Out-of-range move, then a free move up.
    cycle(4'b0100, 1'b0); idle(2);
    cycle(4'b0001, 1'b0); idle(LAT + 2);

    // Wall hit to the right, then back to the menu.
    map_mem[19] = 30'b10;
    cycle(4'b1000, 1'b0); idle(LAT + 2);
    cycle(4'b0001, 1'b1); idle(1);

    // Clear map, walk to the goal, then poke buttons while won.
    map_mem[19] = '0;
    cycle(4'b0000, 1'b1); wait_play();
    for (int k = 0; k < 29; k++) begin cycle(4'b1000, 1'b0); wait_play(); end
    for (int k = 0; k < 20; k++) begin cycle(4'b0001, 1'b0); wait_play(); idle(LAT + 1); end
    cycle(4'b1111, 1'b0); cycle(4'b0100, 1'b0); cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b1); idle(1);

    // Asynchronous reset in the middle of CHECK and of SHOW.
    cycle(4'b0000, 1'b1); wait_play();
    cycle(4'b0001, 1'b0);
    async_reset("reset_mid_check");
    cycle(4'b0000, 1'b1); idle(1);
    async_reset("reset_mid_show");

    // Randomized play on random maps.
    random_map();
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] d;
      logic s;
      int r;
      r = $urandom_range(0, 99);
      d = '0;
      s = 1'b0;
      if (r < 40)      d = 4'(1 << $urandom_range(0, 3));
      else if (r < 48) d = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 99) < ((m_mode == MD_MENU) ? 25 : 8)) s = 1'b1;
      if (m_mode == MD_MENU && $urandom_range(0, 9) == 0) random_map();
      cycle(d, s);
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/maze_game_sequencer.md
Name: maze_game_sequencer

Overview:
- Top-level flow controller for the memory-maze game. Owns the game FSM (menu, show map, playing, lost, won), menu and difficulty selection, and the map-reveal timer.
- Sequences the map ROM read used for wall-collision checks on every attempted move.
- Sits between the debounced button pulses and the VGA renderer and map ROM; the renderer consumes its state, selection and position outputs.

Parameters:
- MAP_W, 30, map columns; bit index of a map ROM word
- MAP_H, 21, map rows; map ROM depth
- START_X, 0, player column after reset and after each new game
- START_Y, 20, player row after reset and after each new game
- GOAL_X, 29, goal column
- GOAL_Y, 0, goal row
- SHOW_EASY, 100000000, map-visible cycles in easy mode
- SHOW_MED, 50000000, map-visible cycles in medium mode
- SHOW_HARD, 25000000, map-visible cycles in hard mode
- ROM_LAT, 1, map ROM read latency in cycles; legal values are 1 or 2

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dir_pulse  in  4  one-cycle move pulses: [0] up, [1] down, [2] left, [3] right
- sel_pulse  in  1  one-cycle select pulse
- rom_addr  out  5  map ROM row address
- rom_data  in  30  map ROM row; bit x set means wall
- game_state  out  4  one-hot: 0001 menu, 0010 in_game, 0100 lost, 1000 won
- menu_sel  out  3  one-hot: 001 start, 010 difficulty, 100 instructions
- difficulty  out  3  one-hot: 001 easy, 010 medium, 100 hard
- map_visible  out  1  renderer draws walls when high
- player_x  out  8  player column
- player_y  out  8  player row
- lost  out  1  high while in lost state
- won  out  1  high while in won state

Behaviour:
- Reset (asynchronous, any state) forces these values immediately:
  - game_state=menu, menu_sel=start, difficulty=easy
  - map_visible=0, player_x=START_X, player_y=START_Y
  - rom_addr=0, lost=0, won=0, timer=0
- Internal states: MENU, SHOW, PLAY, CHECK, LOST, WON.
  - game_state reports in_game for SHOW, PLAY and CHECK.
- MENU:
  - dir up/down rotates menu_sel, with wrap: start->difficulty->instructions->start for down, reverse for up.
  - When menu_sel=difficulty, left/right rotates difficulty with wrap: easy<->medium<->hard.
  - sel with menu_sel=start: load timer with the SHOW_* value for the current difficulty, set map_visible=1, place the player at start, go to SHOW.
  - sel in any other menu position is ignored.
- SHOW:
  - Timer decrements by 1 per cycle.
  - When the timer reaches 1, the next edge enters PLAY with map_visible=0. Total time in SHOW is exactly SHOW_* cycles.
  - All button pulses are ignored.
- PLAY, on a dir pulse:
  - Compute the candidate position.
  - A move that would leave 0..MAP_W-1 or 0..MAP_H-1 is discarded; the state stays PLAY.
  - Otherwise drive rom_addr=candidate y and enter CHECK.
- CHECK:
  - Wait ROM_LAT cycles, then sample rom_data[candidate x].
  - Bit set: go to LOST with lost=1; the position is not committed.
  - Bit clear: commit the candidate to player_x/player_y. Go to WON (won=1) if it equals the goal, otherwise back to PLAY.
  - Pulses arriving during CHECK are dropped, not queued.
- LOST/WON:
  - sel returns to MENU, clears lost/won and restores the start position.
  - menu_sel and difficulty are retained.
- Simultaneous dir bits in one cycle: priority up > down > left > right. Exactly one move is taken.
- A sel and a dir pulse in the same cycle: sel wins in MENU, LOST and WON; dir wins in PLAY.
- Arithmetic:
  - Position math is done in 9-bit signed to detect the underflow at 0.
  - The timer is 27 bits; it must hold SHOW_EASY.
- Map-render address generation is outside this block. The ROM port is used only in CHECK; rom_addr holds its last value otherwise.

Decomposition:
- Shared package game_pkg holds:
  - one-hot encodings for game_state, menu_sel and difficulty
  - internal FSM state constants
  - direction bit indices
- One natural sub-module: reveal_timer, a loadable 27-bit down-counter with an expire output.

Test Plan:
- Run with SHOW_EASY=10, SHOW_MED=6, SHOW_HARD=3.
- Reset, then down, down, down -> menu_sel goes 010, 100, 001; difficulty stays 001.
- down, right, right, up, sel -> difficulty=100; map_visible high for exactly 3 cycles, then game_state=0010 with map_visible=0.
- In PLAY at (0,20): left -> discarded, position stays (0,20) and no ROM access. Then up with rom_data=0 -> position (0,19) after ROM_LAT+1 cycles.
- In PLAY at (0,19): right with rom_data bit1=1 -> lost=1, game_state=0100, position stays (0,19). Then sel -> menu, position (0,20).
- Load a map with a clear path and drive it to (29,0) -> won=1, game_state=1000. dir pulses in WON have no effect.
- Assert reset mid-CHECK and mid-SHOW -> all outputs immediately take their reset values, with no waiting for a clock edge.
